// File: rtl/arith_arb_pkg.sv
// Shared types for the two-requester arithmetic issue arbiter.
// Opcode constants and the {valid, id, op} tag carried down the pipe.
package arith_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       id;
    logic [1:0] op;
  } arb_tag_t;

  // Reserved opcode runs and reports as ADD.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == OP_RSV) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/arith_tag_pipe.sv
// Tag shift register, one stage per unit latency cycle.
// Exposes the head opcode, the tail tag and an any-valid flag.
module arith_tag_pipe
  import arith_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  arb_tag_t tag_i,
  output logic [1:0] head_op_o,
  output arb_tag_t tail_o,
  output logic     busy_o
);

  arb_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

  assign head_op_o = stage_q[0].op;
  assign tail_o    = stage_q[DEPTH-1];

endmodule

// File: rtl/arith_issue_arbiter.sv
// Round-robin issue of two requesters onto shared add/sub and multiply units.
// Optional grant counters are built when ARITH_ARB_STATS_EN is defined.
module arith_issue_arbiter
  import arith_arb_pkg::*;
#(
  parameter int arbWidth = 8
) (
  input  logic                  arbClock,
  input  logic                  resetPos,
  input  logic [1:0]            reqValid,
  output logic [1:0]            reqReady,
  input  logic [1:0]            reqOp0,
  input  logic [arbWidth-1:0]   reqA0,
  input  logic [arbWidth-1:0]   reqB0,
  input  logic [1:0]            reqOp1,
  input  logic [arbWidth-1:0]   reqA1,
  input  logic [arbWidth-1:0]   reqB1,
  input  logic                  arbHold,
  output logic                  rspValid,
  output logic                  rspId,
  output logic [2*arbWidth-1:0] rspResult,
  output logic                  rspOverflow,
  output logic                  busy
`ifdef ARITH_ARB_STATS_EN
  ,
  output logic [15:0]           grantCnt0,
  output logic [15:0]           grantCnt1
`endif
);

  localparam int W = arbWidth;

  logic         rr_q;
  logic         gnt_id;
  logic         accept;
  logic [1:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  arb_tag_t     tag_in;
  logic [1:0]   head_op;
  arb_tag_t     tail;

  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [W:0]     as_q;
  logic [W:0]     as_d;
  logic           as_ovf_q;
  logic           as_ovf_d;
  logic [W-1:0]   b_eff;
  logic           sub_sel;
  logic [2*W-1:0] mul_q;

  logic           rsp_v_q;
  logic           rsp_id_q;
  logic [2*W-1:0] rsp_res_q;
  logic [2*W-1:0] rsp_res_d;
  logic           rsp_ovf_q;
  logic           rsp_ovf_d;

  always_comb begin
    gnt_id   = (&reqValid) ? rr_q : reqValid[1];
    reqReady = 2'b00;
    if (!resetPos && !arbHold && (|reqValid)) begin
      reqReady = gnt_id ? 2'b10 : 2'b01;
    end
  end

  assign accept = |reqReady;
  assign sel_op = gnt_id ? reqOp1 : reqOp0;
  assign sel_a  = gnt_id ? reqA1 : reqA0;
  assign sel_b  = gnt_id ? reqB1 : reqB0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.id    = gnt_id;
    tag_in.op    = norm_op(sel_op);
  end

  always_ff @(posedge arbClock) begin
    if (resetPos) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~gnt_id;
    end
  end

  arith_tag_pipe #(
    .DEPTH (2)
  ) u_tag_pipe (
    .clk_i     (arbClock),
    .rst_i     (resetPos),
    .tag_i     (tag_in),
    .head_op_o (head_op),
    .tail_o    (tail),
    .busy_o    (busy)
  );

  // Shared operand registers feed both units.
  always_ff @(posedge arbClock) begin
    if (resetPos) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      opa_q <= sel_a;
      opb_q <= sel_b;
    end
  end

  // Add/sub unit: op select follows the head tag, aligned to opa_q/opb_q.
  always_comb begin
    sub_sel  = (head_op == OP_SUB);
    b_eff    = sub_sel ? ~opb_q : opb_q;
    as_d     = {1'b0, opa_q} + {1'b0, b_eff} + {{W{1'b0}}, sub_sel};
    as_ovf_d = (opa_q[W-1] == b_eff[W-1]) && (as_d[W-1] != opa_q[W-1]);
  end

  always_ff @(posedge arbClock) begin
    if (resetPos) begin
      as_q     <= '0;
      as_ovf_q <= 1'b0;
      mul_q    <= '0;
    end else begin
      as_q     <= as_d;
      as_ovf_q <= as_ovf_d;
      mul_q    <= (2*W)'(opa_q) * (2*W)'(opb_q);
    end
  end

  always_comb begin
    rsp_res_d = '0;
    rsp_ovf_d = 1'b0;
    if (tail.valid) begin
      unique case (1'b1)
        (tail.op == OP_MUL): rsp_res_d = mul_q;
        default: begin
          rsp_res_d = {{(W-1){1'b0}}, as_q};
          rsp_ovf_d = as_ovf_q;
        end
      endcase
    end
  end

  always_ff @(posedge arbClock) begin
    if (resetPos) begin
      rsp_v_q   <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_res_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      rsp_v_q   <= tail.valid;
      rsp_id_q  <= tail.valid & tail.id;
      rsp_res_q <= rsp_res_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign rspValid    = rsp_v_q;
  assign rspId       = rsp_id_q;
  assign rspResult   = rsp_res_q;
  assign rspOverflow = rsp_ovf_q;

`ifdef ARITH_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge arbClock) begin
    if (resetPos) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (reqReady[0]) cnt0_q <= cnt0_q + 16'd1;
      if (reqReady[1]) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grantCnt0 = cnt0_q;
  assign grantCnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_arith_issue_arbiter.sv
// Bench for arith_issue_arbiter: queue-based reference model of grants and responses.
// Grant counter checks are built when ARITH_ARB_STATS_EN is defined.
module tb_arith_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [1:0]  rdy;
  logic [1:0]  op0, op1;
  logic [7:0]  a0, b0, a1, b1;
  logic        hold;
  logic        rv, rid, rovf, busy;
  logic [15:0] rres;
`ifdef ARITH_ARB_STATS_EN
  logic [15:0] gc0, gc1;
`endif

  always #5 clk = ~clk;

  arith_issue_arbiter #(.arbWidth(8)) dut (
    .arbClock    (clk),
    .resetPos    (rst),
    .reqValid    (vld),
    .reqReady    (rdy),
    .reqOp0      (op0),
    .reqA0       (a0),
    .reqB0       (b0),
    .reqOp1      (op1),
    .reqA1       (a1),
    .reqB1       (b1),
    .arbHold     (hold),
    .rspValid    (rv),
    .rspId       (rid),
    .rspResult   (rres),
    .rspOverflow (rovf),
    .busy        (busy)
`ifdef ARITH_ARB_STATS_EN
    ,
    .grantCnt0   (gc0),
    .grantCnt1   (gc1)
`endif
  );

  typedef struct {
    int          e;
    bit          id;
    logic [15:0] res;
    bit          ovf;
  } ent_t;

  ent_t        pend[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edges = 0;
  bit          rr_m = 1'b0;
  int          cnt0_m = 0;
  int          cnt1_m = 0;
  logic [1:0]  exp_rdy;
  logic [1:0]  last_acc;
  logic [21:0] exp_v, obs_v;

  function automatic ent_t mk(bit id, logic [1:0] op,
                              logic [7:0] a, logic [7:0] b, int e);
    ent_t t;
    int sa, sb, s;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    t.id = id;
    t.e  = e;
    if (op == 2'd2) begin
      t.res = 16'(int'(a) * int'(b));
      t.ovf = 1'b0;
    end else if (op == 2'd1) begin
      s = sa - sb;
      t.res = 16'(((a >= b) ? 256 : 0) + ((int'(a) - int'(b) + 256) % 256));
      t.ovf = (s < -128) || (s > 127);
    end else begin
      s = sa + sb;
      t.res = 16'(int'(a) + int'(b));
      t.ovf = (s < -128) || (s > 127);
    end
    return t;
  endfunction

  task automatic model_eval();
    bit e_rv, e_id, e_ovf, e_busy;
    logic [15:0] e_res;
    e_rv = 0; e_id = 0; e_ovf = 0; e_busy = 0; e_res = '0;
    exp_rdy = 2'b00;
    if (!rst && !hold && vld != 2'b00)
      exp_rdy = (vld == 2'b11) ? (rr_m ? 2'b10 : 2'b01) : vld;
    foreach (pend[k]) begin
      if (pend[k].e == edges - 2) begin
        e_rv = 1; e_id = pend[k].id; e_res = pend[k].res; e_ovf = pend[k].ovf;
      end
      if (pend[k].e >= edges - 1) e_busy = 1;
    end
    exp_v = {exp_rdy, e_rv, e_id, e_res, e_ovf, e_busy};
    obs_v = {rdy, rv, rid, rres, rovf, busy};
  endtask

  task automatic tick();
    bit g;
    model_eval();
    @(posedge clk);
    edges++;
    last_acc = exp_rdy;
    if (rst) begin
      pend.delete();
      rr_m = 0; cnt0_m = 0; cnt1_m = 0;
    end else if (exp_rdy != 2'b00) begin
      g = exp_rdy[1];
      pend.push_back(mk(g, g ? op1 : op0, g ? a1 : a0, g ? b1 : b0, edges));
      rr_m = ~g;
      if (g) cnt1_m = (cnt1_m + 1) % 65536;
      else   cnt0_m = (cnt0_m + 1) % 65536;
    end
    while (pend.size() > 0 && pend[0].e < edges - 2) void'(pend.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; vld = 0; hold = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick();
    tick();
    #1;
    n_cmp++;
    if ({rdy, rv, rid, rres, rovf, busy} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=0", {rdy, rv, rid, rres, rovf, busy});
    end
    rst = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin
      vld = (i == 0) ? 2'b01 : 2'b00;
      op0 = 2'd0; a0 = 8'h05; b0 = 8'h03;
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL basic i=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin
        n_cmp++;
        if (rdy !== 2'b01) begin
          n_bad++;
          $display("FAIL basic_grant got=%b exp=01", rdy);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({rv, rid, rres, rovf} !== {1'b1, 1'b0, 16'h0008, 1'b0}) begin
          n_bad++;
          $display("FAIL basic_rsp got=%b/%b/%h/%b exp=1/0/0008/0", rv, rid, rres, rovf);
        end
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    rst = 1; vld = 0; tick(); rst = 0;
    for (int k = 0; k < 12; k++) begin
      vld = (k < 9) ? 2'b11 : 2'b00;
      op0 = 2'd2; a0 = 8'h0F; b0 = 8'h0F;
      op1 = 2'd1; a1 = 8'h10; b1 = 8'h01;
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL alternate k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
      if (k < 9) begin
        n_cmp++;
        if (rdy !== ((k % 2) ? 2'b10 : 2'b01)) begin
          n_bad++;
          $display("FAIL alt_grant k=%0d got=%b", k, rdy);
        end
      end
      if (k >= 3 && k < 12) begin
        n_cmp++;
        if ({rv, rid, rres} !== {1'b1, 1'(k % 2 == 0), ((k % 2) ? 16'h00E1 : 16'h010F)}) begin
          n_bad++;
          $display("FAIL alt_rsp k=%0d got=%b/%b/%h", k, rv, rid, rres);
        end
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      vld = (i < 2) ? 2'b10 : 2'b00;
      op1 = (i == 0) ? 2'd0 : 2'd3;
      a1 = (i == 0) ? 8'h7F : 8'hFF;
      b1 = 8'h01;
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL overflow i=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if ({rv, rid, rres, rovf} !==
            ((i == 3) ? {1'b1, 1'b1, 16'h0080, 1'b1} : {1'b1, 1'b1, 16'h0100, 1'b0})) begin
          n_bad++;
          $display("FAIL ovf_rsp i=%0d got=%b/%b/%h/%b", i, rv, rid, rres, rovf);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      vld = (i < 8) ? 2'b11 : 2'b00;
      hold = (i >= 1 && i <= 5);
      op0 = 2'($urandom_range(0, 3)); a0 = 8'($urandom); b0 = 8'($urandom);
      op1 = 2'($urandom_range(0, 3)); a1 = 8'($urandom); b1 = 8'($urandom);
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL hold i=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (hold) begin
        n_cmp++;
        if (rdy !== 2'b00) begin
          n_bad++;
          $display("FAIL hold_ready i=%0d got=%b exp=00", i, rdy);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_busy got=%b exp=0", busy);
        end
      end
      tick();
    end
    hold = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      vld = 2'b11;
      rst = (i == 2);
      op0 = 2'd0; a0 = 8'h11; b0 = 8'h22;
      op1 = 2'd2; a1 = 8'h03; b1 = 8'h04;
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid i=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i == 3) begin
        n_cmp++;
        if ({rdy, rv, rid, rres, rovf, busy} !== {2'b01, 20'd0}) begin
          n_bad++;
          $display("FAIL reset_after got=%h exp=%h", {rdy, rv, rid, rres, rovf, busy}, {2'b01, 20'd0});
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (rv !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_discard got=%b exp=0", rv);
        end
      end
      tick();
    end
    rst = 0; vld = 0;
  endtask

  task automatic test_random();
    bit         pv[2];
    logic [1:0] pop[2];
    logic [7:0] pa[2], pb[2];
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1;
          pop[i] = 2'($urandom_range(0, 3));
          pa[i] = 8'($urandom); pb[i] = 8'($urandom);
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 0;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      vld = {pv[1], pv[0]};
      op0 = pop[0]; a0 = pa[0]; b0 = pb[0];
      op1 = pop[1]; a1 = pa[1]; b1 = pb[1];
      #1; model_eval();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      tick();
      for (int i = 0; i < 2; i++) if (last_acc[i]) pv[i] = 0;
    end
    hold = 0; vld = 0;
    for (int c = 0; c < 3; c++) tick();
  endtask

`ifdef ARITH_ARB_STATS_EN
  task automatic test_stats();
    rst = 1; vld = 0; tick(); rst = 0;
    op0 = 2'd0; op1 = 2'd1;
    for (int i = 0; i < 8; i++) begin
      vld = (i < 5) ? 2'b01 : 2'b10;
      tick();
    end
    vld = 0;
    #1;
    n_cmp++;
    if ({gc0, gc1} !== {16'd5, 16'd3} || {gc0, gc1} !== {16'(cnt0_m), 16'(cnt1_m)}) begin
      n_bad++;
      $display("FAIL stats_count got=%0d/%0d exp=5/3", gc0, gc1);
    end
    vld = 2'b01;
    for (int i = 0; i < 65530; i++) tick();
    vld = 0;
    #1;
    n_cmp++;
    if (gc0 !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL stats_preload got=%h exp=FFFF", gc0);
    end
    vld = 2'b01;
    tick();
    vld = 0;
    #1;
    n_cmp++;
    if (gc0 !== 16'h0000 || gc0 !== 16'(cnt0_m)) begin
      n_bad++;
      $display("FAIL stats_wrap got=%h exp=0000", gc0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef ARITH_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
